// File: rtl/ldpc_iter_ctrl.sv
// LDPC iteration scheduler: one LOAD sweep, then CN/VN row sweeps with a syndrome check per iteration.
// Define LDPC_ITER_ABORT_EN to add an abort input that ends the decode early, unsuccessfully.
module ldpc_iter_ctrl #(
  parameter int unsigned ITER_BITS = 4,
  parameter int unsigned ROW_BITS  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ITER_BITS-1:0] max_iter,
  input  logic [ROW_BITS-1:0]  n_rows,
  input  logic                 syndrome_ok,
`ifdef LDPC_ITER_ABORT_EN
  input  logic                 abort,
`endif
  output logic                 load_en,
  output logic                 cn_en,
  output logic                 vn_en,
  output logic [ROW_BITS-1:0]  row_idx,
  output logic [ITER_BITS-1:0] iter,
  output logic                 busy,
  output logic                 done,
  output logic                 success
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CN    = 3'd2,
    S_VN    = 3'd3,
    S_CHECK = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [ROW_BITS-1:0]  n_rows_q, n_rows_d;
  logic [ITER_BITS-1:0] max_iter_q, max_iter_d;
  logic [ROW_BITS-1:0]  row_d;
  logic [ITER_BITS-1:0] iter_d;
  logic                 success_d;
  logic [ROW_BITS-1:0]  row_last_c;
  logic [ITER_BITS-1:0] iter_last_c;

  // Zero limits behave as one row / one iteration.
  always_comb begin
    row_last_c  = (n_rows_q == '0) ? '0 : n_rows_q - ROW_BITS'(1);
    iter_last_c = (max_iter_q == '0) ? '0 : max_iter_q - ITER_BITS'(1);
  end

  always_comb begin
    state_d    = state_q;
    n_rows_d   = n_rows_q;
    max_iter_d = max_iter_q;
    row_d      = row_idx;
    iter_d     = iter;
    success_d  = success;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_rows_d   = n_rows;
          max_iter_d = max_iter;
          row_d      = '0;
          iter_d     = '0;
          success_d  = 1'b0;
          state_d    = S_LOAD;
        end
      end
      S_LOAD, S_CN, S_VN: begin
        if (row_idx == row_last_c) begin
          row_d = '0;
          if (state_q == S_LOAD)    state_d = S_CN;
          else if (state_q == S_CN) state_d = S_VN;
          else                      state_d = S_CHECK;
        end else begin
          row_d = row_idx + ROW_BITS'(1);
        end
      end
      S_CHECK: begin
        if (syndrome_ok) begin
          success_d = 1'b1;
          state_d   = S_DONE;
        end else if (iter == iter_last_c) begin
          success_d = 1'b0;
          state_d   = S_DONE;
        end else begin
          iter_d  = iter + ITER_BITS'(1);
          state_d = S_CN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

`ifdef LDPC_ITER_ABORT_EN
    // Abort overrides every working-state decision, including a passing syndrome.
    if (abort && (state_q != S_IDLE) && (state_q != S_DONE)) begin
      state_d   = S_DONE;
      success_d = 1'b0;
      row_d     = '0;
      iter_d    = iter;
    end
`endif
  end

  // Outputs are registered from the next state so every strobe lines up with its state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      n_rows_q   <= '0;
      max_iter_q <= '0;
      row_idx    <= '0;
      iter       <= '0;
      success    <= 1'b0;
      load_en    <= 1'b0;
      cn_en      <= 1'b0;
      vn_en      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_rows_q   <= n_rows_d;
      max_iter_q <= max_iter_d;
      row_idx    <= row_d;
      iter       <= iter_d;
      success    <= success_d;
      load_en    <= (state_d == S_LOAD);
      cn_en      <= (state_d == S_CN);
      vn_en      <= (state_d == S_VN);
      busy       <= (state_d != S_IDLE);
      done       <= (state_d == S_DONE);
    end
  end

endmodule
